// File: rtl/rot_pkg.sv
// Shared types and helpers for the HEX digit rotation controller.
//   state_e        : controller FSM states (hold / auto-run)
//   PHASE_W        : width of the rotation offset register
//   NUM_CHARS      : characters in the rotating word (u, v, w, x)
//   sel_for_digit  : select code for digit i at a given rotation offset
package rot_pkg;

  typedef enum logic {
    S_HOLD = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam int PHASE_W   = 2;
  localparam int NUM_CHARS = 4;

  // Digit i shows character (i + phase) mod 4. NUM_CHARS equals
  // 2**PHASE_W, so plain PHASE_W-bit addition performs the modulo.
  function automatic logic [PHASE_W-1:0] sel_for_digit(
    input int                 i,
    input logic [PHASE_W-1:0] phase
  );
    logic [PHASE_W-1:0] offset;
    offset = PHASE_W'(i);
    return offset + phase;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that paces the rotation in auto-run mode.
// Ports:
//   clk    in  system clock, rising edge
//   resetn in  synchronous active-low reset, count returns to 0
//   clr    in  force the count to 0 (has priority over en)
//   en     in  advance the count by one this cycle
//   term   out high while en is set and the count sits at TICK_DIV-1;
//              the count wraps to 0 at that same edge
// With en low the count simply holds.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam int                 CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign term = en && (cnt_q == LAST);

  // NOTE: every signal driven in always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = term ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every
  // flop samples the values from before the edge regardless of order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hex_rotate_ctrl.sv
// Rotation controller for the character-select / 7-segment mux. Rotates
// the 4-character word across NUM_DIGITS digit positions, either once per
// prescaled tick (run=1) or by single-step pulses while held (run=0).
// Ports:
//   clk      in   system clock, rising edge
//   resetn   in   synchronous active-low reset
//   run      in   1 = auto-rotate, 0 = hold
//   step     in   single-step request, rising edge honoured only in hold
//   dir      in   0 = phase+1, 1 = phase-1 (sampled at the update edge)
//   sel_bus  out  select code per digit, digit i at bits [2i+1:2i]
//   phase    out  current rotation offset
//   tick     out  one-cycle pulse in the cycle after each phase change edge
//   running  out  1 while the FSM is in S_RUN
//   blank    out  (only with ROT_BLANK_EN) high for one tick period after
//                 an auto-run wrap; rotation pauses for that period
// Build option: define ROT_BLANK_EN to add the blank output and the pause
// after each wrap. Without it rotation is continuous.
module hex_rotate_ctrl
  import rot_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    run,
  input  logic                    step,
  input  logic                    dir,
  output logic [2*NUM_DIGITS-1:0] sel_bus,
  output logic [PHASE_W-1:0]      phase,
  output logic                    tick,
  output logic                    running
`ifdef ROT_BLANK_EN
  ,
  output logic                    blank
`endif
);

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               tick_q,  tick_d;
  logic               step_q,  step_d;
  logic               advance;
  logic               pre_clr;
  logic               pre_en;
  logic               pre_term;
`ifdef ROT_BLANK_EN
  logic               blank_q, blank_d;
`endif

  // Clear on entry to RUN; count only while staying in RUN. Dropping run
  // deasserts en, so the count holds and a terminal count is not honoured.
  assign pre_clr = (state_q == S_HOLD) && run;
  assign pre_en  = (state_q == S_RUN)  && run;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .resetn (resetn),
    .clr    (pre_clr),
    .en     (pre_en),
    .term   (pre_term)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    step_d  = step;
    advance = 1'b0;
`ifdef ROT_BLANK_EN
    blank_d = blank_q;
`endif

    case (state_q)
      S_HOLD: begin
        // Entering RUN wins over a coincident step edge.
        if (run) begin
          state_d = S_RUN;
        end else if (step && !step_q) begin
          advance = 1'b1;
        end
      end
      S_RUN: begin
        if (!run) begin
          state_d = S_HOLD;
`ifdef ROT_BLANK_EN
          blank_d = 1'b0;
`endif
        end else if (pre_term) begin
`ifdef ROT_BLANK_EN
          // The terminal count that ends a blank period only clears it;
          // the following one resumes rotation from the wrapped phase.
          if (blank_q) begin
            blank_d = 1'b0;
          end else begin
            advance = 1'b1;
            blank_d = dir ? (phase_q == '0) : (phase_q == '1);
          end
`else
          advance = 1'b1;
`endif
        end
      end
      default: state_d = S_HOLD;
    endcase

    if (advance) begin
      phase_d = dir ? phase_q - PHASE_W'(1) : phase_q + PHASE_W'(1);
    end
    tick_d = advance;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_HOLD;
      phase_q <= '0;
      tick_q  <= 1'b0;
      step_q  <= 1'b0;
`ifdef ROT_BLANK_EN
      blank_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
      step_q  <= step_d;
`ifdef ROT_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  // Decoded from the phase register alone, so the whole bus changes in the
  // same cycle as phase and carries no input-dependent glitches.
  always_comb begin
    sel_bus = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_bus[2*i +: 2] = sel_for_digit(i, phase_q);
    end
  end

  assign phase   = phase_q;
  assign tick    = tick_q;
  assign running = (state_q == S_RUN);
`ifdef ROT_BLANK_EN
  assign blank   = blank_q;
`endif

endmodule

// File: doc/hex_rotate_ctrl.md
Name: hex_rotate_ctrl

Overview:
- Upstream control stage for the character-select/7-segment mux: generates the 2-bit select code for each HEX digit position.
- Rotates the 4-character word (u,v,w,x) across the digits.
- Rotation advances once per prescaled tick in RUN, or by single-step pulses while held.
- Each digit's select slice drives the s input of one character mux/decoder instance.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per rotation step in RUN (1 s at 50 MHz); legal range >= 1.
- NUM_DIGITS, 4: number of digit positions driven; legal range 1..8.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- run  in  1  level; 1 = auto-rotate, 0 = hold.
- step  in  1  single-step request; rising edge honoured only while held.
- dir  in  1  0 = advance (phase+1), 1 = reverse (phase-1).
- sel_bus  out  2*NUM_DIGITS  select code per digit; digit i at bits [2i+1:2i].
- phase  out  2  current rotation offset.
- tick  out  1  one-cycle pulse coincident with each phase change.
- running  out  1  1 while FSM is in S_RUN.

Behaviour:
- Reset (resetn=0 at an edge) sets:
  - state=S_HOLD, phase=0, prescaler count=0, tick=0, running=0, step edge register=0.
  - sel_bus digit i = i mod 4; for NUM_DIGITS=4 this is 8'b11_10_01_00.
- Reset mid-operation has the same effect; no partial step completes.
- sel_bus digit i = (i + phase) mod 4, decoded from the phase register only. It changes in the same cycle as phase and is glitch-free.
- Phase update:
  - dir=0: phase <= phase+1 mod 4 (3 wraps to 0).
  - dir=1: phase <= phase-1 mod 4 (0 wraps to 3).
  - dir is sampled at the update edge.
- FSM:
  - S_HOLD to S_RUN when run=1. The prescaler clears to 0 on this transition; running=1 from the next cycle.
  - S_RUN to S_HOLD when run=0. The prescaler holds its value, and no advance happens in that cycle even if it is the terminal count.
- S_RUN:
  - count increments every cycle.
  - At count==TICK_DIV-1: count <= 0, phase advances, tick=1 for that one cycle.
  - First advance occurs TICK_DIV cycles after entering S_RUN.
  - TICK_DIV=1 gives an advance every cycle.
- S_HOLD:
  - Step edge detection: step_q <= step; a rising edge is step & ~step_q.
  - A rising edge advances phase at the next edge and pulses tick.
  - A held-high step yields exactly one advance.
  - Step edges in S_RUN are ignored and are not queued.
- Simultaneous run 0 to 1 and step edge: the transition wins; the step is dropped.
- tick is registered: high exactly when phase has just changed, never high two cycles for one step.

Optional Feature:
- Macro: ROT_BLANK_EN.
- Defined:
  - Adds output blank (1 bit, reset 0).
  - When phase wraps from 3 to 0 in S_RUN (dir=0) or from 0 to 3 (dir=1), blank=1 for one full tick period (TICK_DIV cycles).
  - During that period the phase advance is suppressed. The next terminal count clears blank and resumes rotation from the wrapped phase.
  - Leaving S_RUN clears blank immediately.
  - Step advances never assert blank.
- Undefined: the blank port is absent, and rotation is continuous with no gap.

Decomposition:
- Package rot_pkg:
  - state enum {S_HOLD, S_RUN}.
  - PHASE_W=2 and NUM_CHARS=4.
  - Function sel_for_digit(i, phase).
- Sub-module tick_prescaler, parameter TICK_DIV:
  - Ports clk, resetn, clr, en, term.
  - Counter width $clog2(TICK_DIV) with a minimum of 1.
- The top holds the FSM, step edge detect, phase register and sel_bus decode.

Test Plan (TICK_DIV=4, NUM_DIGITS=4):
- Reset: resetn=0 for 2 cycles, then release with run=0 -> phase=0, sel_bus=8'b11_10_01_00, tick=0, running=0.
- Auto-rotate: run=1, dir=0 for 16 cycles -> 4 tick pulses spaced 4 cycles apart, first 4 cycles after entry. phase 1,2,3,0; sel_bus after the first tick = 8'b00_11_10_01.
- Reverse wrap: phase=0, run=0, single step pulse with dir=1 -> phase=3 next cycle, tick=1 for exactly 1 cycle. Holding step high for 10 more cycles produces no further change.
- Run dropped at terminal count: run=1, deassert run on the cycle count==3 -> no advance, running=0, tick=0. Re-asserting run restarts the count from 0.
- Step ignored in RUN and reset mid-run: step pulses while run=1 leave the tick spacing unchanged. resetn=0 at count==2, phase=2 -> phase=0 and state=S_HOLD at the next edge.
- ROT_BLANK_EN: run=1, dir=0 from phase=3 -> at the wrap, phase=0 and blank=1 for 4 cycles with no advance, then phase=1 and blank=0.
